// File: rtl/mem_copier_if.sv
// Memory-side bus of mem_copier: one shared address for read and write,
// separate read/write strobes, write data out and combinational read data in.
interface mem_copier_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic [AW-1:0] Data_address;
    logic          Data_read_en;
    logic          Data_write_en;
    logic [DW-1:0] Data_memory_in;
    logic [DW-1:0] Data_memory_out;

    // Copier side: drives address, strobes and write data.
    modport master (
        output Data_address,
        output Data_read_en,
        output Data_write_en,
        output Data_memory_in,
        input  Data_memory_out
    );

    // Memory side: returns read data.
    modport slave (
        input  Data_address,
        input  Data_read_en,
        input  Data_write_en,
        input  Data_memory_in,
        output Data_memory_out
    );
endinterface

// File: rtl/mem_copier.sv
// mem_copier: byte-by-byte ascending memory copy, 2 cycles per byte
// (RD then WR) over a single-pointer memory bus. All outputs are registered
// and derived from the next state, so they are valid for the whole cycle of
// the state they belong to and clear asynchronously on reset.
// Optional macro MEMCPY_FILL_EN adds a fill mode (fill, fill_value) that
// skips the reads and writes fill_value in consecutive WR cycles.
module mem_copier #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [7:0]    len,
`ifdef MEMCPY_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_value,
`endif
    output logic          busy,
    output logic          done,
    mem_copier_if.master  mem
);

    localparam int unsigned LW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] hold_reg_q, hold_reg_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    logic          wr_en_q, wr_en_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // Selected write data for the upcoming WR cycle and the state that follows a WR.
    logic [DW-1:0] wr_value_c;
    state_e        loop_state_c;

`ifdef MEMCPY_FILL_EN
    logic          fill_q, fill_d;
    logic [DW-1:0] fill_val_q, fill_val_d;
`endif

    // State, datapath and registered-output flops.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            cnt_q      <= '0;
            hold_reg_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= '0;
`ifdef MEMCPY_FILL_EN
            fill_q     <= 1'b0;
            fill_val_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            cnt_q      <= cnt_d;
            hold_reg_q <= hold_reg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wdata_q    <= wdata_d;
`ifdef MEMCPY_FILL_EN
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
`endif
        end
    end

    // Next-state, pointer/count update and next-cycle bus outputs.
    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        cnt_d        = cnt_q;
        hold_reg_d   = hold_reg_q;
        wr_value_c   = hold_reg_q;
        loop_state_c = RD;
`ifdef MEMCPY_FILL_EN
        fill_d       = fill_q;
        fill_val_d   = fill_val_q;
        if (fill_q) begin
            loop_state_c = WR;
        end
`endif

        case (state_q)
            IDLE: begin
                // abort outranks start; a zero-length request touches no memory
                if (start && !abort) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        src_ptr_d = src_addr;
                        dst_ptr_d = dst_addr;
                        cnt_d     = len;
                        state_d   = RD;
`ifdef MEMCPY_FILL_EN
                        fill_d     = fill;
                        fill_val_d = fill_value;
                        if (fill) begin
                            state_d = WR;
                        end
`endif
                    end
                end
            end
            RD: begin
                // hold_reg only ever loads here, while the bus is driven
                hold_reg_d = mem.Data_memory_out;
                state_d    = abort ? IDLE : WR;
            end
            WR: begin
                src_ptr_d = src_ptr_q + AW'(1);
                dst_ptr_d = dst_ptr_q + AW'(1);
                cnt_d     = cnt_q - LW'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_d != '0) begin
                    state_d = loop_state_c;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Write data for the coming WR cycle: freshly read byte, or the fill value.
        wr_value_c = hold_reg_d;
`ifdef MEMCPY_FILL_EN
        if (fill_d) begin
            wr_value_c = fill_val_d;
        end
`endif

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            RD: begin
                rd_en_d = 1'b1;
                addr_d  = src_ptr_d;
            end
            WR: begin
                wr_en_d = 1'b1;
                addr_d  = dst_ptr_d;
                wdata_d = wr_value_c;
            end
            default: begin
                rd_en_d = 1'b0;
            end
        endcase
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign mem.Data_address   = addr_q;
    assign mem.Data_read_en   = rd_en_q;
    assign mem.Data_write_en  = wr_en_q;
    assign mem.Data_memory_in = wdata_q;

endmodule

// File: tb/tb_mem_copier.sv
// Directed bench for mem_copier with a 256-byte behavioural memory.
module tb_mem_copier;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;
`ifdef MEMCPY_FILL_EN
    logic       fill;
    logic [7:0] fill_value;
`endif

    mem_copier_if #(.AW(8), .DW(8)) bus ();

    mem_copier #(.AW(8), .DW(8)) dut (
        .CLK      (clk),
        .reset    (rst_n),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
`ifdef MEMCPY_FILL_EN
        .fill       (fill),
        .fill_value (fill_value),
`endif
        .busy     (busy),
        .done     (done),
        .mem      (bus)
    );

    logic [7:0] mem [256];
    int n_vec;
    int n_err;
    int rd_cnt, wr_cnt, both_cnt, done_cnt, idle_bad;
    logic [7:0] rd_log [$];
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write commits on posedge.
    assign bus.Data_memory_out = bus.Data_read_en ? mem[bus.Data_address] : 8'hxx;
    always @(posedge clk) begin
        if (bus.Data_write_en) mem[bus.Data_address] <= bus.Data_memory_in;
    end

    // Bus activity monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Data_read_en) begin
                rd_cnt++;
                rd_log.push_back(bus.Data_address);
            end
            if (bus.Data_write_en) wr_cnt++;
            if (bus.Data_read_en && bus.Data_write_en) both_cnt++;
            if (done) done_cnt++;
            if (!busy && (bus.Data_read_en || bus.Data_write_en ||
                          bus.Data_address != 8'h00 || bus.Data_memory_in != 8'h00))
                idle_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; done_cnt = 0;
        rd_log.delete();
    endtask

    // Pulse start for one edge; returns 1 time unit after the sampling edge.
    task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle index (1 = cycle right after the start edge) in which done is high.
    task automatic wait_done(input int lim, output int c);
        c = 1;
        while (!done && c < lim) begin
            @(posedge clk);
            #1 c++;
        end
        if (!done) c = -1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; idle_bad = 0;
        clear_mon();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
`ifdef MEMCPY_FILL_EN
        fill = 1'b0; fill_value = '0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(bus.Data_address), 32'd0);
        check("rst_strobes", 32'({bus.Data_read_en, bus.Data_write_en}), 32'd0);
        check("rst_wdata", 32'(bus.Data_memory_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic copy: M[16..19] -> M[100..103]
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'(i + 1);
        clear_mon();
        launch(8'd16, 8'd100, 8'd4);
        wait_done(50, cyc);
        check("copy_latency", 32'(cyc), 32'd9);
        @(posedge clk);
        #1;
        check("copy_busy_after", 32'(busy), 32'd0);
        check("copy_done_after", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) check("copy_data", 32'(mem[100 + i]), 32'(i + 1));
        idle_cycles(2);
        check("copy_rd_count", 32'(rd_cnt), 32'd4);
        check("copy_wr_count", 32'(wr_cnt), 32'd4);
        check("copy_done_count", 32'(done_cnt), 32'd1);

        // Wrap and overlap propagation
        mem[254] = 8'd7; mem[255] = 8'd8; mem[0] = 8'd9;
        clear_mon();
        launch(8'd254, 8'd0, 8'd3);
        wait_done(50, cyc);
        check("wrap_latency", 32'(cyc), 32'd7);
        idle_cycles(2);
        check("wrap_m0", 32'(mem[0]), 32'd7);
        check("wrap_m1", 32'(mem[1]), 32'd8);
        check("wrap_m2", 32'(mem[2]), 32'd7);
        check("wrap_rd_count", 32'(rd_cnt), 32'd3);
        if (rd_log.size() == 3) check("wrap_rd_addr", 32'(rd_log[2]), 32'd0);
        else check("wrap_rd_log_size", 32'(rd_log.size()), 32'd3);

        // Zero-length request
        clear_mon();
        launch(8'd5, 8'd6, 8'd0);
        wait_done(10, cyc);
        check("len0_latency", 32'(cyc), 32'd1);
        idle_cycles(3);
        check("len0_strobes", 32'(rd_cnt + wr_cnt), 32'd0);
        check("len0_done_count", 32'(done_cnt), 32'd1);

        // Abort in 2nd WR of a len=5 copy, with a stray start while busy
        for (int i = 0; i < 5; i++) begin
            mem[32 + i] = 8'(8'h11 + i);
            mem[64 + i] = 8'h00;
        end
        clear_mon();
        launch(8'd32, 8'd64, 8'd5);
        @(posedge clk);
        #1 start = 1'b1; src_addr = 8'd200; len = 8'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_wr_phase", 32'(bus.Data_write_en), 32'd1);
        check("abort_wr_addr", 32'(bus.Data_address), 32'd65);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        idle_cycles(4);
        check("abort_m64", 32'(mem[64]), 32'h11);
        check("abort_m65", 32'(mem[65]), 32'h12);
        check("abort_m66", 32'(mem[66]), 32'h00);
        check("abort_wr_count", 32'(wr_cnt), 32'd2);
        check("abort_done_count", 32'(done_cnt), 32'd0);
        if (rd_log.size() == 2) check("abort_rd_src", 32'(rd_log[1]), 32'd33);
        else check("abort_rd_log_size", 32'(rd_log.size()), 32'd2);

        // abort together with start in IDLE: start is dropped
        @(negedge clk);
        abort = 1'b1; start = 1'b1; len = 8'd2;
        @(posedge clk);
        #1 abort = 1'b0; start = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd0);

        // abort in DONE keeps the pulse
        clear_mon();
        launch(8'd16, 8'd140, 8'd1);
        wait_done(20, cyc);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        idle_cycles(2);
        check("abort_in_done_cnt", 32'(done_cnt), 32'd1);
        check("abort_in_done_m140", 32'(mem[140]), 32'd1);

        // Asynchronous reset mid-RD, then a fresh copy
        clear_mon();
        launch(8'd16, 8'd120, 8'd4);
        check("arst_in_rd", 32'(bus.Data_read_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs",
              32'({busy, done, bus.Data_read_en, bus.Data_write_en, bus.Data_address, bus.Data_memory_in}),
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        check("arst_idle_busy", 32'(busy), 32'd0);
        clear_mon();
        launch(8'd16, 8'd120, 8'd4);
        wait_done(50, cyc);
        check("arst_recopy_latency", 32'(cyc), 32'd9);
        idle_cycles(2);
        for (int i = 0; i < 4; i++) check("arst_recopy_data", 32'(mem[120 + i]), 32'(i + 1));

`ifdef MEMCPY_FILL_EN
        // Fill mode
        clear_mon();
        @(negedge clk);
        fill = 1'b1; fill_value = 8'hA5;
        launch(8'd0, 8'd10, 8'd3);
        fill = 1'b0;
        wait_done(20, cyc);
        check("fill_latency", 32'(cyc), 32'd4);
        idle_cycles(2);
        for (int i = 0; i < 3; i++) check("fill_data", 32'(mem[10 + i]), 32'hA5);
        check("fill_rd_count", 32'(rd_cnt), 32'd0);
`endif

        check("strobe_overlap", 32'(both_cnt), 32'd0);
        check("idle_outputs_zero", 32'(idle_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
